// File: rtl/alu_pkg.sv
// alu_pkg: operation codes and FSM encoding shared by the multi-cycle ALU
// and the ALU control decoder.
package alu_pkg;

    localparam logic [3:0] ALU_ADD     = 4'b0000;
    localparam logic [3:0] ALU_SUB     = 4'b0001;
    localparam logic [3:0] ALU_OR      = 4'b0010;
    localparam logic [3:0] ALU_AND     = 4'b0011;
    localparam logic [3:0] ALU_LUI     = 4'b0100;
    localparam logic [3:0] ALU_SLL     = 4'b0101;
    localparam logic [3:0] ALU_SRL     = 4'b0110;
    localparam logic [3:0] ALU_XOR     = 4'b0111;
    localparam logic [3:0] ALU_BEQ     = 4'b1000;
    localparam logic [3:0] ALU_BNE     = 4'b1001;
    localparam logic [3:0] ALU_BLT     = 4'b1010;
    localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// alu_shift_unit: one-bit-per-cycle shifter with down-counter, or a
// single-cycle barrel shifter when ALU_SHIFT_FAST_EN is defined.
module alu_shift_unit
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load_i,
    input  logic                          left_i,
    input  logic [DATA_WIDTH-1:0]         a_i,
    input  logic [$clog2(DATA_WIDTH)-1:0] shamt_i,
    output logic [DATA_WIDTH-1:0]         result_o,
    output logic                          last_o
);

    localparam int SHW = $clog2(DATA_WIDTH);

`ifdef ALU_SHIFT_FAST_EN

    logic unused;
    assign unused = ^{clk, rst_n, load_i};

    // Whole shift resolves combinationally from the request operands
    always_comb begin
        result_o = left_i ? (a_i << shamt_i) : (a_i >> shamt_i);
        last_o   = 1'b0;
    end

`else

    localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

    logic [DATA_WIDTH-1:0] sh_q;
    logic [DATA_WIDTH-1:0] sh_step;
    logic [SHW-1:0]        cnt_q;
    logic                  left_q;

    // Next one-bit step; also the final result on the last cycle
    always_comb begin
        if (left_q) begin
            sh_step = {sh_q[DATA_WIDTH-2:0], 1'b0};
        end else begin
            sh_step = {1'b0, sh_q[DATA_WIDTH-1:1]};
        end
        result_o = sh_step;
        last_o   = (cnt_q == CNT_ONE);
    end

    // Load on accept, then shift and count down until empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            left_q <= 1'b0;
        end else if (load_i) begin
            sh_q   <= a_i;
            cnt_q  <= shamt_i;
            left_q <= left_i;
        end else if (cnt_q != '0) begin
            sh_q  <= sh_step;
            cnt_q <= cnt_q - CNT_ONE;
        end
    end

`endif

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked ALU with iterative shifts.
// Define ALU_SHIFT_FAST_EN for single-cycle shifts.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [3:0]            ALU_Operation_i,
    input  logic [DATA_WIDTH-1:0] A_i,
    input  logic [DATA_WIDTH-1:0] B_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] ALU_Result_o,
    output logic                  Zero_o,
    output logic                  Branch_Taken_o,
    output logic                  Illegal_o
);

    localparam int SHW = $clog2(DATA_WIDTH);

    alu_state_t            state_q;
    alu_state_t            state_d;
    logic                  accept;
    logic                  op_shift;
    logic                  sh_multi;
    logic                  sh_last;
    logic [SHW-1:0]        shamt;
    logic [DATA_WIDTH-1:0] sh_res;
    logic [DATA_WIDTH-1:0] sh_first;
    logic [DATA_WIDTH-1:0] diff;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_br;
    logic                  alu_ill;

    assign accept   = valid_i && ready_o;
    assign op_shift = is_shift(ALU_Operation_i);
    assign shamt    = B_i[SHW-1:0];
    assign diff     = A_i - B_i;

`ifdef ALU_SHIFT_FAST_EN
    assign sh_multi = 1'b0;
    assign sh_first = sh_res;
`else
    assign sh_multi = op_shift && (shamt != '0);
    assign sh_first = A_i;
`endif

    alu_shift_unit #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shift (
        .clk      (clk),
        .rst_n    (reset),
        .load_i   (accept && op_shift),
        .left_i   (ALU_Operation_i == ALU_SLL),
        .a_i      (A_i),
        .shamt_i  (shamt),
        .result_o (sh_res),
        .last_o   (sh_last)
    );

    // Single-cycle result, branch and legality decode of the request
    always_comb begin
        alu_res = '0;
        alu_br  = 1'b0;
        alu_ill = 1'b0;
        unique case (1'b1)
            (ALU_Operation_i == ALU_ADD): alu_res = A_i + B_i;
            (ALU_Operation_i == ALU_SUB): alu_res = diff;
            (ALU_Operation_i == ALU_OR):  alu_res = A_i | B_i;
            (ALU_Operation_i == ALU_AND): alu_res = A_i & B_i;
            (ALU_Operation_i == ALU_LUI): alu_res = B_i;
            (ALU_Operation_i == ALU_XOR): alu_res = A_i ^ B_i;
            op_shift:                     alu_res = sh_first;
            (ALU_Operation_i == ALU_BEQ): begin
                alu_res = diff;
                alu_br  = (A_i == B_i);
            end
            (ALU_Operation_i == ALU_BNE): begin
                alu_res = diff;
                alu_br  = (A_i != B_i);
            end
            (ALU_Operation_i == ALU_BLT): begin
                alu_res = diff;
                alu_br  = ($signed(A_i) < $signed(B_i));
            end
            default: alu_ill = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept in IDLE, iterate in SHIFT, hold DONE until taken
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = sh_multi ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (sh_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state; never both high
    always_comb begin
        ready_o = (state_q == ST_IDLE);
        valid_o = (state_q == ST_DONE);
    end

    // Result and flags captured together; frozen while waiting in DONE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ALU_Result_o   <= '0;
            Zero_o         <= 1'b0;
            Branch_Taken_o <= 1'b0;
            Illegal_o      <= 1'b0;
        end else if (accept && !sh_multi) begin
            ALU_Result_o   <= alu_res;
            Zero_o         <= (alu_res == '0);
            Branch_Taken_o <= alu_br;
            Illegal_o      <= alu_ill;
        end else if ((state_q == ST_SHIFT) && sh_last) begin
            ALU_Result_o   <= sh_res;
            Zero_o         <= (sh_res == '0);
            Branch_Taken_o <= 1'b0;
            Illegal_o      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed vectors with a scoreboard queue and a
// monitor that checks each result as valid_o rises.
module tb_alu_multicycle;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         valid_i = 1'b0;
    logic         ready_i = 1'b1;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ready_o;
    logic         valid_o;
    logic [W-1:0] res_o;
    logic         zero_o;
    logic         br_o;
    logic         ill_o;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         br;
        logic         ill;
        int           lat;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    logic prev_v = 1'b0;

    alu_multicycle #(
        .DATA_WIDTH (W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .ALU_Operation_i(op),
        .A_i            (a),
        .B_i            (b),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .ALU_Result_o   (res_o),
        .Zero_o         (zero_o),
        .Branch_Taken_o (br_o),
        .Illegal_o      (ill_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] got,
                       input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    function automatic int slat(input int n);
`ifdef ALU_SHIFT_FAST_EN
        return 1;
`else
        return 1 + n;
`endif
    endfunction

    // Monitor: record acceptance cycle, check each response on valid_o rise
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            prev_v = 1'b0;
        end else begin
            chk("ready_valid_excl", W'(ready_o && valid_o), '0);
            if (valid_i && ready_o) acc_cyc = cyc;
            if (valid_o && !prev_v) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_valid got result %h want none", res_o);
                end else begin
                    e = sb.pop_front();
                    chk("result", res_o, e.res);
                    chk("zero", W'(zero_o), W'(e.z));
                    chk("branch", W'(br_o), W'(e.br));
                    chk("illegal", W'(ill_o), W'(e.ill));
                    chk("latency", W'(cyc - acc_cyc), W'(e.lat));
                end
            end
            prev_v = valid_o;
        end
    end

    task automatic drive(input logic [3:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        int n;
        op = o;
        a = x;
        b = y;
        valid_i = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout got ready_o 0 want 1");
        end
        @(posedge clk);
        #1 valid_i = 1'b0;
    endtask

    task automatic send(input logic [3:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] r,
                        input logic br, input logic ill, input int lat);
        sb.push_back('{r, (r == '0), br, ill, lat});
        drive(o, x, y);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout got %0d pending want 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, W'(ready_o), 1);
        chk({tag, "_valid"}, W'(valid_o), 0);
        chk({tag, "_result"}, res_o, 0);
        chk({tag, "_zero"}, W'(zero_o), 0);
        chk({tag, "_branch"}, W'(br_o), 0);
        chk({tag, "_illegal"}, W'(ill_o), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 chk_reset_state("por");
        reset = 1'b1;
        @(posedge clk);
        #1;

        send(ALU_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 0, 1);
        send(ALU_SUB, 32'h0, 32'h1, 32'hFFFF_FFFF, 0, 0, 1);
        send(ALU_OR, 32'h0000_F0F0, 32'h0000_0F00, 32'h0000_FFF0, 0, 0, 1);
        send(ALU_AND, 32'h0000_FF00, 32'h0000_0FF0, 32'h0000_0F00, 0, 0, 1);
        send(ALU_LUI, 32'h1234_5678, 32'hABCD_E000, 32'hABCD_E000, 0, 0, 1);
        send(ALU_XOR, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0, 0, 0, 1);
        send(ALU_BLT, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE, 1, 0, 1);
        send(ALU_BLT, 32'h1, 32'hFFFF_FFFF, 32'h2, 0, 0, 1);
        send(ALU_BEQ, 32'h5, 32'h5, 32'h0, 1, 0, 1);
        send(ALU_BNE, 32'h5, 32'h5, 32'h0, 0, 0, 1);
        send(ALU_BNE, 32'h7, 32'h5, 32'h2, 1, 0, 1);
        send(ALU_ILLEGAL, 32'h5, 32'h6, 32'h0, 0, 1, 1);
        send(4'b1011, 32'h5, 32'h6, 32'h0, 0, 1, 1);
        drain();

        send(ALU_SLL, 32'h1, 32'd31, 32'h8000_0000, 0, 0, slat(31));
        send(ALU_SRL, 32'h8000_0000, 32'h24, 32'h0800_0000, 0, 0, slat(4));
        send(ALU_SLL, 32'h0000_1234, 32'h20, 32'h0000_1234, 0, 0, slat(0));
        send(ALU_SRL, 32'hF000_000F, 32'd1, 32'h7800_0007, 0, 0, slat(1));
        drain();

        // Reset while a long shift is in flight
`ifdef ALU_SHIFT_FAST_EN
        sb.push_back('{32'h0010_0000, 1'b0, 1'b0, 1'b0, 1});
`endif
        drive(ALU_SLL, 32'h1, 32'd20);
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        #1 chk_reset_state("mid_shift");
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        send(ALU_ADD, 32'h3, 32'h4, 32'h7, 0, 0, 1);
        drain();

        // Backpressure with a second request waiting
        ready_i = 1'b0;
        send(ALU_ADD, 32'd10, 32'd20, 32'd30, 0, 0, 1);
        op = ALU_SUB;
        a = 32'd50;
        b = 32'd8;
        valid_i = 1'b1;
        sb.push_back('{32'd42, 1'b0, 1'b0, 1'b0, 1});
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid", W'(valid_o), 1);
            chk("bp_ready", W'(ready_o), 0);
            chk("bp_result", res_o, 32'd30);
        end
        @(posedge clk);
        #1 ready_i = 1'b1;
        @(negedge clk);
        chk("pre_take_ready", W'(ready_o), 0);
        @(posedge clk);
        @(negedge clk);
        chk("post_take_ready", W'(ready_o), 1);
        chk("post_take_valid", W'(valid_o), 0);
        @(posedge clk);
        #1 valid_i = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
